// File: rtl/cory_unpack8.sv
// cory_unpack8: splits one valid/ready word stream into eight independent
// valid/ready bit-slice lanes; the word retires once every lane has its slice.
//
// Ports
//   clk, reset_n          clock, async active-low reset
//   i_a_v, i_a_d, o_a_r   input word stream (Z bits wide)
//   o_zk_v, o_zk_d        lane k valid / slice k of i_a_d (Ak bits)
//   i_zk_r                lane k ready
module cory_unpack8 #(
   parameter int N  = 8,
   parameter int A0 = N,
   parameter int A1 = N,
   parameter int A2 = N,
   parameter int A3 = N,
   parameter int A4 = N,
   parameter int A5 = N,
   parameter int A6 = N,
   parameter int A7 = N,
   localparam int Z = A0 + A1 + A2 + A3 + A4 + A5 + A6 + A7
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          i_a_v,
   input  logic [Z-1:0]  i_a_d,
   output logic          o_a_r,
   output logic          o_z0_v,
   output logic [A0-1:0] o_z0_d,
   input  logic          i_z0_r,
   output logic          o_z1_v,
   output logic [A1-1:0] o_z1_d,
   input  logic          i_z1_r,
   output logic          o_z2_v,
   output logic [A2-1:0] o_z2_d,
   input  logic          i_z2_r,
   output logic          o_z3_v,
   output logic [A3-1:0] o_z3_d,
   input  logic          i_z3_r,
   output logic          o_z4_v,
   output logic [A4-1:0] o_z4_d,
   input  logic          i_z4_r,
   output logic          o_z5_v,
   output logic [A5-1:0] o_z5_d,
   input  logic          i_z5_r,
   output logic          o_z6_v,
   output logic [A6-1:0] o_z6_d,
   input  logic          i_z6_r,
   output logic          o_z7_v,
   output logic [A7-1:0] o_z7_d,
   input  logic          i_z7_r
);

   localparam int OFF1 = A0;
   localparam int OFF2 = OFF1 + A1;
   localparam int OFF3 = OFF2 + A2;
   localparam int OFF4 = OFF3 + A3;
   localparam int OFF5 = OFF4 + A4;
   localparam int OFF6 = OFF5 + A5;
   localparam int OFF7 = OFF6 + A6;

   logic [7:0] done;
   logic [7:0] rdy;
   logic [7:0] vld;
   logic [7:0] take;

   assign rdy = {i_z7_r, i_z6_r, i_z5_r, i_z4_r,
                 i_z3_r, i_z2_r, i_z1_r, i_z0_r};

   // A lane that already took the current word stays quiet until it retires.
   assign vld  = {8{i_a_v}} & ~done;
   assign take = vld & rdy;

   // Retire once every lane has either taken earlier or is taking now.
   assign o_a_r = &(done | take);

   assign o_z0_v = vld[0];
   assign o_z1_v = vld[1];
   assign o_z2_v = vld[2];
   assign o_z3_v = vld[3];
   assign o_z4_v = vld[4];
   assign o_z5_v = vld[5];
   assign o_z6_v = vld[6];
   assign o_z7_v = vld[7];

   assign o_z0_d = i_a_d[0    +: A0];
   assign o_z1_d = i_a_d[OFF1 +: A1];
   assign o_z2_d = i_a_d[OFF2 +: A2];
   assign o_z3_d = i_a_d[OFF3 +: A3];
   assign o_z4_d = i_a_d[OFF4 +: A4];
   assign o_z5_d = i_a_d[OFF5 +: A5];
   assign o_z6_d = i_a_d[OFF6 +: A6];
   assign o_z7_d = i_a_d[OFF7 +: A7];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         done <= 8'h00;
      end else if (i_a_v && o_a_r) begin
         done <= 8'h00;
      end else begin
         done <= done | take;
      end
   end

endmodule

// File: tb/tb_cory_unpack8.sv
// tb_cory_unpack8: directed checks of cory_unpack8 (uniform and
// non-uniform slice widths) plus a random valid/ready scoreboard run.
module tb_cory_unpack8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n;
   logic        a_v;
   logic [63:0] a_d;
   logic        a_r;
   logic [7:0]  zv;
   logic [7:0]  zr;
   logic [7:0]  zd [8];

   logic        b_v;
   logic [27:0] b_d;
   logic        b_r;
   logic [7:0]  bv;
   logic [7:0]  br;
   logic        bd0;
   logic [2:0]  bd1;
   logic [3:0]  bd2, bd3, bd4, bd5, bd6, bd7;

   cory_unpack8 u_dut (
      .clk(clk), .reset_n(reset_n),
      .i_a_v(a_v), .i_a_d(a_d), .o_a_r(a_r),
      .o_z0_v(zv[0]), .o_z0_d(zd[0]), .i_z0_r(zr[0]),
      .o_z1_v(zv[1]), .o_z1_d(zd[1]), .i_z1_r(zr[1]),
      .o_z2_v(zv[2]), .o_z2_d(zd[2]), .i_z2_r(zr[2]),
      .o_z3_v(zv[3]), .o_z3_d(zd[3]), .i_z3_r(zr[3]),
      .o_z4_v(zv[4]), .o_z4_d(zd[4]), .i_z4_r(zr[4]),
      .o_z5_v(zv[5]), .o_z5_d(zd[5]), .i_z5_r(zr[5]),
      .o_z6_v(zv[6]), .o_z6_d(zd[6]), .i_z6_r(zr[6]),
      .o_z7_v(zv[7]), .o_z7_d(zd[7]), .i_z7_r(zr[7])
   );

   cory_unpack8 #(
      .A0(1), .A1(3), .A2(4), .A3(4),
      .A4(4), .A5(4), .A6(4), .A7(4)
   ) u_dut_nu (
      .clk(clk), .reset_n(reset_n),
      .i_a_v(b_v), .i_a_d(b_d), .o_a_r(b_r),
      .o_z0_v(bv[0]), .o_z0_d(bd0), .i_z0_r(br[0]),
      .o_z1_v(bv[1]), .o_z1_d(bd1), .i_z1_r(br[1]),
      .o_z2_v(bv[2]), .o_z2_d(bd2), .i_z2_r(br[2]),
      .o_z3_v(bv[3]), .o_z3_d(bd3), .i_z3_r(br[3]),
      .o_z4_v(bv[4]), .o_z4_d(bd4), .i_z4_r(br[4]),
      .o_z5_v(bv[5]), .o_z5_d(bd5), .i_z5_r(br[5]),
      .o_z6_v(bv[6]), .o_z6_d(bd6), .i_z6_r(br[6]),
      .o_z7_v(bv[7]), .o_z7_d(bd7), .i_z7_r(br[7])
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag,
                      input logic [63:0] obs,
                      input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] sl(input logic [63:0] w, input int k);
      return w[k*8 +: 8];
   endfunction

   localparam logic [63:0] W0 = 64'h7766554433221100;
   localparam logic [63:0] W1 = 64'hFFEEDDCCBBAA9988;
   localparam int NW = 300;

   logic [63:0] wq [2];
   logic [63:0] rw [NW];
   int cnt [8];
   int widx;
   int cyc;
   bit retired;

   task automatic drv();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n = 1'b0;
      a_v = 1'b0; a_d = '0; zr = '0;
      b_v = 1'b0; b_d = '0; br = '0;
      #12;
      chk("rst_a_r", 64'(a_r), 64'h0);
      chk("rst_zv", 64'(zv), 64'h0);
      drv();
      reset_n = 1'b1;

      // all lanes ready: single-cycle pass-through
      drv();
      a_d = W0; a_v = 1'b1; zr = 8'hFF;
      @(negedge clk);
      for (int k = 0; k < 8; k++)
         chk($sformatf("t1_d%0d", k), 64'(zd[k]), 64'(8'h11 * k));
      chk("t1_zv", 64'(zv), 64'hFF);
      chk("t1_a_r", 64'(a_r), 64'h1);
      drv();
      @(negedge clk);
      chk("t1_zv_next", 64'(zv), 64'hFF);
      chk("t1_a_r_next", 64'(a_r), 64'h1);

      // lane 3 stalled for four cycles
      drv();
      zr = 8'hF7;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk($sformatf("t2_a_r_c%0d", c), 64'(a_r), 64'h0);
         chk($sformatf("t2_zv_c%0d", c), 64'(zv),
             (c == 0) ? 64'hFF : 64'h08);
         drv();
      end
      zr = 8'hFF;
      @(negedge clk);
      chk("t2_a_r_rel", 64'(a_r), 64'h1);
      chk("t2_zv_rel", 64'(zv), 64'h08);
      drv();
      a_v = 1'b0; zr = 8'h00;

      // staggered readies, two back-to-back words
      wq[0] = W0; wq[1] = W1;
      for (int k = 0; k < 8; k++) cnt[k] = 0;
      widx = 0; cyc = 0;
      drv();
      a_v = 1'b1; a_d = W0;
      while (widx < 2 && cyc < 40) begin
         for (int k = 0; k < 8; k++) zr[k] = (cyc >= k);
         @(negedge clk);
         for (int k = 0; k < 8; k++) begin
            if (zv[k] && zr[k]) begin
               if (cnt[k] < 2)
                  chk($sformatf("t3_d%0d_w%0d", k, cnt[k]),
                      64'(zd[k]), 64'(sl(wq[cnt[k]], k)));
               else
                  chk($sformatf("t3_dup%0d", k), 64'(cnt[k]), 64'd1);
               cnt[k]++;
            end
         end
         if (a_v && a_r) widx++;
         drv();
         cyc++;
         if (widx == 1) a_d = W1;
         if (widx >= 2) a_v = 1'b0;
      end
      chk("t3_words", 64'(widx), 64'd2);
      for (int k = 0; k < 8; k++)
         chk($sformatf("t3_cnt%0d", k), 64'(cnt[k]), 64'd2);
      a_v = 1'b0; zr = 8'h00;

      // non-uniform slice widths
      b_d = 28'hABCDEF5; b_v = 1'b1;
      @(negedge clk);
      chk("t4_d0", 64'(bd0), 64'h1);
      chk("t4_d1", 64'(bd1), 64'h2);
      chk("t4_d2", 64'(bd2), 64'hF);
      chk("t4_d3", 64'(bd3), 64'hE);
      chk("t4_d4", 64'(bd4), 64'hD);
      chk("t4_d5", 64'(bd5), 64'hC);
      chk("t4_d6", 64'(bd6), 64'hB);
      chk("t4_d7", 64'(bd7), 64'hA);
      chk("t4_bv", 64'(bv), 64'hFF);
      chk("t4_b_r", 64'(b_r), 64'h0);
      drv();
      b_v = 1'b0;

      // reset after lanes 0..3 took the word
      a_v = 1'b1; a_d = W1; zr = 8'h0F;
      @(negedge clk);
      chk("t5_zv_pre", 64'(zv), 64'hFF);
      drv();
      zr = 8'h00;
      @(negedge clk);
      chk("t5_zv_part", 64'(zv), 64'hF0);
      reset_n = 1'b0;
      #1;
      chk("t5_zv_async", 64'(zv), 64'hFF);
      drv();
      reset_n = 1'b1;
      @(negedge clk);
      chk("t5_zv_after", 64'(zv), 64'hFF);
      chk("t5_a_r_after", 64'(a_r), 64'h0);
      drv();
      a_v = 1'b0;

      // random valid/ready with per-lane scoreboard
      for (int i = 0; i < NW; i++) rw[i] = {$urandom, $urandom};
      for (int k = 0; k < 8; k++) cnt[k] = 0;
      widx = 0; cyc = 0; retired = 1'b0;
      while (widx < NW && cyc < 20000) begin
         drv();
         cyc++;
         if (retired) begin
            a_v = 1'b0;
            retired = 1'b0;
         end
         if (!a_v && $urandom_range(0, 3) != 0) begin
            a_v = 1'b1;
            a_d = rw[widx];
         end
         zr = 8'($urandom);
         @(negedge clk);
         for (int k = 0; k < 8; k++) begin
            if (zv[k] && zr[k]) begin
               chk("t6_order", 64'(cnt[k]), 64'(widx));
               chk("t6_data", 64'(zd[k]), 64'(sl(rw[widx], k)));
               cnt[k]++;
            end
         end
         if (a_v && a_r) begin
            for (int k = 0; k < 8; k++)
               chk("t6_retire", 64'(cnt[k]), 64'(widx + 1));
            widx++;
            retired = 1'b1;
         end
      end
      drv();
      a_v = 1'b0;
      chk("t6_words", 64'(widx), 64'(NW));
      for (int k = 0; k < 8; k++)
         chk($sformatf("t6_cnt%0d", k), 64'(cnt[k]), 64'(NW));

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
